// File: rtl/imm_encoder.sv
// Packs a 64-bit immediate plus register/opcode fields into an RV64 I/S-type word, with range check.
// Latency: entry is at the buffer head the cycle after acceptance; 2-entry FIFO, no bypass.
// Backpressure: in_ready depends only on occupancy (low when FULL), never on out_ready.
module imm_encoder (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [63:0] in_imm,
   input  logic [3:0]  in_sel,
   input  logic [4:0]  in_rs1,
   input  logic [4:0]  in_rs2_rd,
   input  logic [2:0]  in_funct3,
   input  logic [6:0]  in_opcode,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic        out_err,
   output logic [15:0] cnt_ok,
   output logic [15:0] cnt_err
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic        r_wptr;
   logic        r_rptr;
   logic [32:0] r_mem [2];
   logic [32:0] r_last;

   logic        w_push;
   logic        w_pop;
   logic        w_sel_ok;
   logic        w_range_ok;
   logic        w_legal;
   logic [31:0] w_instr_i;
   logic [31:0] w_instr_s;
   logic [32:0] w_entry;
   logic [32:0] w_head;

   assign in_ready  = (r_state != ST_FULL);
   assign out_valid = (r_state != ST_EMPTY);
   assign w_push    = in_valid && in_ready;
   assign w_pop     = out_valid && out_ready;

   // Fits in signed 12 bits iff bits 63:11 are a pure sign extension of bit 11.
   assign w_sel_ok   = (in_sel == 4'd0) || (in_sel == 4'd1);
   assign w_range_ok = (&in_imm[63:11]) || !(|in_imm[63:11]);
   assign w_legal    = w_sel_ok && w_range_ok;

   assign w_instr_i = {in_imm[11:0], in_rs1, in_funct3, in_rs2_rd, in_opcode};
   assign w_instr_s = {in_imm[11:5], in_rs2_rd, in_rs1, in_funct3, in_imm[4:0], in_opcode};

   always_comb begin
      w_entry = {1'b1, 32'h0000_0013};
      if (w_legal) begin
         w_entry = {1'b0, (in_sel == 4'd0) ? w_instr_i : w_instr_s};
      end
   end

   // When empty the head shows the most recently popped entry.
   assign w_head    = out_valid ? r_mem[r_rptr] : r_last;
   assign out_err   = w_head[32];
   assign out_instr = w_head[31:0];

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_EMPTY: if (w_push) w_state_nxt = ST_ONE;
         ST_ONE: begin
            if (w_push && !w_pop)      w_state_nxt = ST_FULL;
            else if (w_pop && !w_push) w_state_nxt = ST_EMPTY;
         end
         ST_FULL:  if (w_pop) w_state_nxt = ST_ONE;
         default:  w_state_nxt = ST_EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_EMPTY;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr <= 1'b0;
         r_rptr <= 1'b0;
         r_last <= '0;
         for (int i = 0; i < 2; i++) begin
            r_mem[i] <= '0;
         end
      end else begin
         if (w_push) begin
            r_mem[r_wptr] <= w_entry;
            r_wptr        <= ~r_wptr;
         end
         if (w_pop) begin
            r_last <= r_mem[r_rptr];
            r_rptr <= ~r_rptr;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_ok  <= '0;
         cnt_err <= '0;
      end else if (w_push) begin
         if (w_legal && (cnt_ok != 16'hFFFF)) begin
            cnt_ok <= cnt_ok + 16'd1;
         end
         if (!w_legal && (cnt_err != 16'hFFFF)) begin
            cnt_err <= cnt_err + 16'd1;
         end
      end
   end

endmodule

// File: doc/imm_encoder.md
# imm_encoder

Packs a 64-bit immediate and register/opcode fields into a 32-bit RV64 instruction word in I-type or S-type format. It is the inverse of the immediate sign-extender in the decode path. The block sits in the instruction-image builder path, where a loader or test sequencer writes instructions into instruction memory. It also checks that each immediate fits a signed 12-bit field. Results pass through a 2-entry output buffer with a valid/ready handshake on both sides.

## Interface
- No parameters. The buffer depth is fixed at 2.
- clk  in  1  single clock; all state updates on its rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  request present
- in_ready  out  1  block can accept a request this cycle
- in_imm  in  64  immediate, two's complement
- in_sel  in  4  format select: 0 = I-type, 1 = S-type; any other value is illegal
- in_rs1  in  5  rs1 field
- in_rs2_rd  in  5  rd for I-type, rs2 for S-type
- in_funct3  in  3  funct3 field
- in_opcode  in  7  opcode field
- out_valid  out  1  buffer head is valid
- out_ready  in  1  consumer accepts the head this cycle
- out_instr  out  32  encoded instruction at the buffer head
- out_err  out  1  the head entry was rejected
- cnt_ok  out  16  saturating count of accepted, legal requests
- cnt_err  out  16  saturating count of accepted, rejected requests

## Operation
- A transfer in occurs when in_valid && in_ready at a rising edge. A transfer out occurs when out_valid && out_ready.
- Range check: the request is legal iff in_sel is 0 or 1 AND in_imm[63:11] are all equal to in_imm[11]. Bits 63:11 all 0s or all 1s means the value lies in -2048..2047.
- I-type encoding: {imm[11:0], rs1, funct3, rd, opcode}.
- S-type encoding: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
- Rejected request: the stored entry is instr = 32'h0000_0013 (addi x0,x0,0) with err = 1.
- Each stored entry is 33 bits: {err, instr}. The buffer is a 2-entry FIFO.
- Occupancy state machine:
  - EMPTY: push only -> ONE.
  - ONE: push only -> FULL; pop only -> EMPTY; push and pop together -> ONE.
  - FULL: pop -> ONE. No push is possible in FULL.
- in_ready = (state != FULL). It is combinational from state only and independent of out_ready, so there is no bypass.
- out_valid = (state != EMPTY). out_instr and out_err always show the head entry. When EMPTY they hold the last popped values, and are 0 after reset.
- Ordering is strict FIFO. Read and write pointers are 1 bit and wrap 1 -> 0.
- Counters:
  - cnt_ok increments on each accepted legal request; cnt_err on each accepted illegal request.
  - Both update at the input transfer edge, not at output.
  - Both saturate at 16'hFFFF with no wrap.
- Reset (rst_n low, asynchronous, at any time including mid-transfer):
  - state = EMPTY, pointers = 0, storage cleared.
  - out_valid = 0, out_instr = 0, out_err = 0, cnt_ok = 0, cnt_err = 0.
  - in_ready = 1 while rst_n is low and after release.
  - Entries in flight are discarded and not counted.
- If in_valid is low, input fields are don't-care. If out_valid is low, out_ready is ignored.

## Timing
- Latency: a request accepted at edge N appears at the head with out_valid = 1 after edge N, provided the buffer was EMPTY or the older entry pops at edge N.
- Throughput: one request per cycle whenever out_ready is held high.
- When FULL, in_ready goes low in the cycle after the second push. It rises in the cycle after the first pop.
- Simultaneous push and pop in state ONE:
  - The head advances to the new entry.
  - Occupancy stays ONE.
  - out_valid stays high.
- Counter values are visible in the cycle after the accepting edge.
- Reset release is synchronous to clk from the user's perspective. The first transfer is legal at the first rising edge with rst_n high.

## Test plan
- I-type legal: imm = 64'hFFFF_FFFF_FFFF_FFFF, rs1 = 2, rd = 1, funct3 = 0, opcode = 7'h13, sel = 0 -> out_instr = 32'hFFF1_0093, out_err = 0, cnt_ok = 1, one cycle after accept.
- S-type legal: imm = 8, rs2 = 5, rs1 = 2, funct3 = 3, opcode = 7'h23, sel = 1 -> out_instr = 32'h0051_3423, out_err = 0.
- Range and select errors, each accepted in turn:
  - imm = 2048, sel = 0 -> out_instr = 32'h0000_0013, out_err = 1.
  - imm = -2049 -> same response.
  - imm = 5, sel = 2 -> same response.
  - After all three, cnt_err = 3.
  - Boundary values imm = 2047 and imm = -2048 are accepted as legal.
- Backpressure: hold out_ready = 0 and offer 3 back-to-back requests -> in_ready drops after the 2nd, and the 3rd is held. Raise out_ready -> all three emerge in order, one per cycle, with no loss or duplication.
- Push+pop in ONE: out_ready = 1, continuous stream of 10 requests -> out_valid stays high, occupancy never reaches FULL, outputs match inputs in order.
- Reset mid-operation: buffer FULL with counters nonzero, assert rst_n low between edges -> out_valid, out_instr, out_err and both counters read 0 immediately, in_ready = 1. The next request after release behaves as in the first scenario.
